// File: rtl/lop_pkg.sv
// rtl/lop_pkg.sv - shared opcode constants, entry type and one-hot helper for the logic-op path
//
// Purpose: common definitions used by the logic-op encoder, its FIFO, the decoder
//          and the operation tests.
// Contents:
//   OP_AND/OP_XOR/OP_OR/OP_NOT  2-bit {A,B} opcodes consumed by the decoder
//   lop_entry_t                 4-bit buffered entry {a,b,o0,o1}
//   onehot4()                   1 when a 4-bit select vector has exactly one bit set

package lop_pkg;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_XOR = 2'b01;
  localparam logic [1:0] OP_OR  = 2'b10;
  localparam logic [1:0] OP_NOT = 2'b11;

  typedef struct packed {
    logic a;
    logic b;
    logic o0;
    logic o1;
  } lop_entry_t;

  // Clearing the lowest set bit leaves zero only when at most one bit was set;
  // the non-zero term rules out the zero-hot case.
  function automatic logic onehot4(input logic [3:0] sel);
    return (sel != 4'd0) && ((sel & (sel - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/lop_fifo.sv
// rtl/lop_fifo.sv - small synchronous FIFO with wrapping pointers and occupancy count
//
// Purpose: buffers encoded logic-op entries between the encoder and the operation unit.
// Parameters: DEPTH (power of two, >= 2), WIDTH (entry bits)
// Ports:
//   clk          in   rising-edge clock
//   rst          in   synchronous active-high reset, empties the FIFO
//   i_push       in   write i_push_data (ignored when full)
//   i_push_data  in   WIDTH-bit entry
//   i_pop        in   advance head (ignored when empty)
//   o_pop_data   out  head entry while non-empty, last popped entry while empty
//   o_full       out  DEPTH entries held
//   o_empty      out  no entries held
//   o_level      out  occupancy, $clog2(DEPTH)+1 bits

module lop_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_push_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_pop_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;
  logic [WIDTH-1:0] r_last;

  logic w_push;
  logic w_pop;

  assign o_full  = (r_level == (AW+1)'(DEPTH));
  assign o_empty = (r_level == '0);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // Pointers wrap naturally at DEPTH because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_last   <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
        r_last   <= r_mem[r_rd_ptr];
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // While empty the head shows the last entry handed downstream (zero after reset).
  assign o_pop_data = o_empty ? r_last : r_mem[r_rd_ptr];
  assign o_level    = r_level;

endmodule

// File: rtl/logic_op_encoder.sv
// rtl/logic_op_encoder.sv - encodes one-hot logic-op requests into {A,B} opcodes and buffers them
//
// Purpose: issue side of the 2-bit logic-op decoder. One-hot AND/OR/XOR/NOT requests with two
//          operand bits are encoded, queued in lop_fifo and drained over a valid/ready link.
//          Zero-hot or multi-hot requests are consumed, dropped and flagged.
// Build option: LOP_ENC_ERRCNT_EN adds parameter ERR_W and a saturating err_count output.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid / in_ready      request handshake (in_ready = !full)
//   req_and/or/xor/not       one-hot operation select
//   in_o0, in_o1             operand bits
//   out_valid / out_ready    head handshake (out_valid = !empty)
//   out_a, out_b             opcode bits for the decoder
//   out_o0, out_o1           operand bits of head
//   err_illegal              1-cycle pulse after an illegal request is consumed
//   level                    FIFO occupancy
//   err_count                saturating illegal-request count (LOP_ENC_ERRCNT_EN only)

module logic_op_encoder
  import lop_pkg::*;
#(
  parameter int DEPTH = 4
`ifdef LOP_ENC_ERRCNT_EN
  ,
  parameter int ERR_W = 8
`endif
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   req_and,
  input  logic                   req_or,
  input  logic                   req_xor,
  input  logic                   req_not,
  input  logic                   in_o0,
  input  logic                   in_o1,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_a,
  output logic                   out_b,
  output logic                   out_o0,
  output logic                   out_o1,
  output logic                   err_illegal,
  output logic [$clog2(DEPTH):0] level
`ifdef LOP_ENC_ERRCNT_EN
  ,
  output logic [ERR_W-1:0]       err_count
`endif
);

  logic [3:0]  w_sel;
  logic        w_legal;
  logic        w_accept;
  logic        w_push;
  logic        w_full;
  logic        w_empty;
  logic [1:0]  w_op;
  lop_entry_t  w_push_entry;
  lop_entry_t  w_head;
  logic [3:0]  w_head_bits;
  logic        r_err_illegal;

  assign w_sel    = {req_and, req_or, req_xor, req_not};
  assign w_legal  = onehot4(w_sel);
  assign in_ready = ~w_full;
  assign w_accept = in_valid & in_ready;
  assign w_push   = w_accept & w_legal;

  always_comb begin
    w_op = OP_AND;
    case (w_sel)
      4'b1000: w_op = OP_AND;
      4'b0100: w_op = OP_OR;
      4'b0010: w_op = OP_XOR;
      4'b0001: w_op = OP_NOT;
      default: w_op = OP_AND;
    endcase
  end

  assign w_push_entry = '{a: w_op[1], b: w_op[0], o0: in_o0, o1: in_o1};

  lop_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (4)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_push_data (w_push_entry),
    .i_pop       (out_valid & out_ready),
    .o_pop_data  (w_head_bits),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_level     (level)
  );

  assign w_head    = lop_entry_t'(w_head_bits);
  assign out_valid = ~w_empty;
  assign out_a     = w_head.a;
  assign out_b     = w_head.b;
  assign out_o0    = w_head.o0;
  assign out_o1    = w_head.o1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_illegal <= 1'b0;
    end else begin
      r_err_illegal <= w_accept & ~w_legal;
    end
  end

  assign err_illegal = r_err_illegal;

`ifdef LOP_ENC_ERRCNT_EN
  logic [ERR_W-1:0] r_err_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_count <= '0;
    end else if (w_accept && !w_legal && (r_err_count != '1)) begin
      r_err_count <= r_err_count + ERR_W'(1);
    end
  end

  assign err_count = r_err_count;
`endif

endmodule
